// File: rtl/xor_parity_sequencer.sv
// Round-robin arbiter sharing one 4-input XOR between NREQ requesters; accumulates word parity a nibble per clock.
// Optional build macro XOR_SEQ_ODD_PARITY_EN: report the odd-parity bit instead of the even-parity bit.
module xor_parity_sequencer #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WORD_W-1:0] data,
  output logic [NREQ-1:0]        gnt,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             done_id,
  output logic                   parity
);

  localparam int NIB   = WORD_W / 4;
  localparam int NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [2:0]        ptr;
  logic [2:0]        winner;
  logic [2:0]        pick;
  logic              found;
  int unsigned       idx;
  logic [WORD_W-1:0] word;
  logic              acc;
  logic [NIB_W-1:0]  nib;
  logic              last;
  logic              nib_x;
  logic              par_even;

  // The work register shifts right each cycle, so the active nibble is always at [3:0].
  assign nib_x    = ^word[3:0];
  assign last     = (nib == NIB_W'(NIB - 1));
  assign par_even = acc ^ nib_x;
  assign busy     = (state == RUN);

  // First set request at or after the pointer, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = 3'(idx);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (found) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      winner  <= '0;
      gnt     <= '0;
      done    <= 1'b0;
      done_id <= '0;
      parity  <= 1'b0;
      word    <= '0;
      acc     <= 1'b0;
      nib     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt    <= NREQ'(1) << pick;
            winner <= pick;
            word   <= data[32'(pick)*WORD_W +: WORD_W];
            acc    <= 1'b0;
            nib    <= '0;
          end
        end
        RUN: begin
          acc  <= par_even;
          word <= word >> 4;
          nib  <= nib + NIB_W'(1);
          if (last) begin
`ifdef XOR_SEQ_ODD_PARITY_EN
            parity <= ~par_even;
`else
            parity <= par_even;
`endif
            done    <= 1'b1;
            done_id <= winner;
            gnt     <= '0;
            ptr     <= (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_parity_sequencer.sv
// Scoreboard bench for xor_parity_sequencer: directed jobs push expected grants/results, a monitor pops and compares.
module tb_xor_parity_sequencer;

  localparam int NREQ   = 4;
  localparam int WORD_W = 16;
  localparam int NIB    = WORD_W / 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] data;
  logic [NREQ-1:0]        gnt;
  logic                   busy;
  logic                   done;
  logic [2:0]             done_id;
  logic                   parity;

  xor_parity_sequencer #(.NREQ(NREQ), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
    .busy(busy), .done(done), .done_id(done_id), .parity(parity)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic p; } done_t;
  done_t dq[$];
  int    gq[$];
  int    compared   = 0;
  int    mismatched = 0;
  int    cyc        = 0;
  int    gcyc       = 0;

  // Hand-computed parities are even-parity values; the odd build inverts them.
  function automatic logic ep(input logic p);
`ifdef XOR_SEQ_ODD_PARITY_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bad(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: grant rising edges and done pulses, popped against the scoreboard.
  initial begin
    logic [NREQ-1:0] prev_gnt;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_gnt = '0;
      end else begin
        if (prev_gnt == '0 && gnt != '0) begin
          if (gq.size() == 0) bad("unexpected_grant");
          else begin
            int e;
            e = gq.pop_front();
            chk("grant", 32'(gnt), 32'(1) << e);
            gcyc = cyc;
          end
        end
        if (done) begin
          chk("done_gnt_overlap", 32'(gnt), 0);
          if (dq.size() == 0) bad("unexpected_done");
          else begin
            done_t d;
            d = dq.pop_front();
            chk("done_id", 32'(done_id), 32'(d.id));
            chk("parity", 32'(parity), 32'(d.p));
            chk("latency", 32'(cyc - gcyc), 32'(NIB));
          end
        end
        prev_gnt = gnt;
      end
    end
  end

  task automatic wait_gnt(input logic [NREQ-1:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt !== exp && n < 40);
    if (gnt !== exp) bad("grant_timeout");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((gq.size() != 0 || dq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (gq.size() != 0 || dq.size() != 0) begin
      bad("drain_timeout");
      gq.delete();
      dq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_job(input int id, input logic [WORD_W-1:0] w, input logic p);
    @(negedge clk);
    data[id*WORD_W +: WORD_W] = w;
    req = NREQ'(1) << id;
    gq.push_back(id);
    dq.push_back('{id, ep(p)});
    wait_gnt(NREQ'(1) << id);
    req = '0;
    wait_drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_done_id", 32'(done_id), 0);
    chk("rst_parity", 32'(parity), 0);
    rst = 1'b0;

    // Single job, with busy observed mid-job.
    @(negedge clk);
    data[0 +: WORD_W] = 16'h0001;
    req = 4'b0001;
    gq.push_back(0);
    dq.push_back('{0, ep(1'b1)});
    wait_gnt(4'b0001);
    req = '0;
    chk("busy_run", 32'(busy), 1);
    wait_drain();
    chk("busy_idle", 32'(busy), 0);

    run_job(0, 16'hFFFF, 1'b0);
    run_job(0, 16'h1234, 1'b1);
    repeat (3) @(negedge clk);
    chk("parity_hold", 32'(parity), 32'(ep(1'b1)));

    // All requests held from reset: 0,1,2,3,0.
    do_reset();
    data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    gq = '{0, 1, 2, 3, 0};
    dq.push_back('{0, ep(1'b1)});
    dq.push_back('{1, ep(1'b0)});
    dq.push_back('{2, ep(1'b1)});
    dq.push_back('{3, ep(1'b0)});
    dq.push_back('{0, ep(1'b1)});
    req = 4'b1111;
    begin
      int n;
      n = 0;
      while (gq.size() != 0 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    req = '0;
    wait_drain();

    // Serve 1, then req=1010 grants 3 then 1; req[3] dropped mid-job.
    run_job(1, 16'h0010, 1'b1);
    @(negedge clk);
    data[3*WORD_W +: WORD_W] = 16'h8001;
    data[1*WORD_W +: WORD_W] = 16'h0070;
    gq.push_back(3);
    dq.push_back('{3, ep(1'b0)});
    gq.push_back(1);
    dq.push_back('{1, ep(1'b1)});
    req = 4'b1010;
    wait_gnt(4'b1000);
    req = 4'b0010;
    wait_gnt(4'b0010);
    req = '0;
    wait_drain();

    // Reset at nibble 2: job lost, pointer back to 0.
    @(negedge clk);
    data[2*WORD_W +: WORD_W] = 16'h0001;
    req = 4'b0100;
    gq.push_back(2);
    wait_gnt(4'b0100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    gq.push_back(1);
    dq.push_back('{1, ep(1'b1)});
    req = 4'b1010;
    wait_gnt(4'b0010);
    req = '0;
    wait_drain();

    // Data changed after grant is ignored.
    @(negedge clk);
    data[0 +: WORD_W] = 16'h0001;
    req = 4'b0001;
    gq.push_back(0);
    dq.push_back('{0, ep(1'b1)});
    wait_gnt(4'b0001);
    data[0 +: WORD_W] = 16'h0003;
    req = '0;
    wait_drain();
    chk("final_parity", 32'(parity), 32'(ep(1'b1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
